hazard_unit_p: RTL

Parametrised pipeline interlock for the RIPTIDE-II core. It generalises the fixed five-stage register scoreboard and seven-stage I/O scoreboard to configurable depths and register address width. It adds a multi-cycle decoder-reset hold counter and a data-cache miss state machine with a recovery cycle. It sits beside the decoder and drives the global stall, branch-stall, flush and decoder-reset lines.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_unit_p_if.sv | 55 +++++
 rtl/hazard_miss_fsm.sv | 55 +++++
 rtl/hazard_unit_p.sv | 120 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the RIPTIDE-II pipeline interlock.
// Operand-source codes and data-cache miss machine states.
package hazard_pkg;

   typedef enum logic [1:0] {
      SRC_REG  = 2'b00,
      SRC_IO   = 2'b01,
      SRC_OVF  = 2'b10,
      SRC_NONE = 2'b11
   } src_e;

   typedef enum logic [1:0] {
      MS_IDLE  = 2'b00,
      MS_RMISS = 2'b01,
      MS_WMISS = 2'b10,
      MS_RECOV = 2'b11
   } miss_state_e;

   localparam int HCNT_W = 4;

endpackage

// File: rtl/hazard_unit_p_if.sv
// Decode-side bundle between the decoder/pipeline and the interlock.
// master drives scoreboard state and decode fields; slave is the interlock.
interface hazard_unit_p_if #(
   parameter int REG_AW    = 3,
   parameter int WR_STAGES = 5,
   parameter int IO_STAGES = 7,
   parameter int BR_STAGES = 3
);
   logic                        JMP;
   logic                        RET;
   logic [BR_STAGES-1:0]        NZT;
   logic [BR_STAGES-1:0]        XEC;
   logic                        NZT_res;
   logic                        XEC_res;
   logic                        CALL_res;
   logic                        ALU_NZ;
   logic                        HALT;
   logic [1:0]                  read_src;
   logic [REG_AW-1:0]           regf_a_read;
   logic                        aux_read;
   logic [WR_STAGES*REG_AW-1:0] regf_w;
   logic [WR_STAGES-1:0]        regf_wren;
   logic [1:0]                  ovf_wr;
   logic [IO_STAGES-1:0]        SC;
   logic [IO_STAGES-1:0]        WC;
   logic [IO_STAGES-1:0]        n_LB_w;
   logic                        n_LB_r;
   logic                        d_cache_miss;
   logic                        hazard;
   logic                        data_hazard;
   logic                        branch_hazard;
   logic                        pipeline_flush;
   logic                        decoder_RST;

   modport master (
      output JMP, RET, NZT, XEC,
      output NZT_res, XEC_res, CALL_res, ALU_NZ, HALT,
      output read_src, regf_a_read, aux_read,
      output regf_w, regf_wren, ovf_wr,
      output SC, WC, n_LB_w, n_LB_r, d_cache_miss,
      input  hazard, data_hazard, branch_hazard,
      input  pipeline_flush, decoder_RST
   );

   modport slave (
      input  JMP, RET, NZT, XEC,
      input  NZT_res, XEC_res, CALL_res, ALU_NZ, HALT,
      input  read_src, regf_a_read, aux_read,
      input  regf_w, regf_wren, ovf_wr,
      input  SC, WC, n_LB_w, n_LB_r, d_cache_miss,
      output hazard, data_hazard, branch_hazard,
      output pipeline_flush, decoder_RST
   );

endinterface

// File: rtl/hazard_miss_fsm.sv
// Data-cache miss machine: stalls from miss detection through one
// recovery cycle after the miss line drops.
module hazard_miss_fsm (
   input  logic clk,
   input  logic n_RST,
   input  logic d_cache_miss,
   input  logic wr_req,
   input  logic rd_req,
   output logic miss_stall,
   output logic data_hazard
);
   import hazard_pkg::*;

   miss_state_e state;
   miss_state_e state_nxt;

   always_ff @(posedge clk or negedge n_RST) begin
      if (!n_RST) state <= MS_IDLE;
      else        state <= state_nxt;
   end

   // Write misses win: the store is further down the pipe.
   always_comb begin
      state_nxt = state;
      unique case (state)
         MS_IDLE: begin
            if (wr_req)      state_nxt = MS_WMISS;
            else if (rd_req) state_nxt = MS_RMISS;
         end
         MS_RMISS,
         MS_WMISS: begin
            if (!d_cache_miss) state_nxt = MS_RECOV;
         end
         MS_RECOV: state_nxt = MS_IDLE;
      endcase
   end

   always_comb begin
      miss_stall  = 1'b0;
      data_hazard = 1'b0;
      unique case (state)
         MS_IDLE: begin
            miss_stall  = wr_req | rd_req;
            data_hazard = wr_req;
         end
         MS_RMISS: miss_stall = 1'b1;
         MS_WMISS: begin
            miss_stall  = 1'b1;
            data_hazard = 1'b1;
         end
         MS_RECOV: miss_stall = 1'b1;
      endcase
   end

endmodule

// File: rtl/hazard_unit_p.sv
// Parametrised RIPTIDE-II interlock: scoreboards, flush hold, miss FSM.
// Optional HAZARD_STATS_EN adds stall/flush counters with stats_clr.
module hazard_unit_p #(
   parameter int REG_AW     = 3,
   parameter int WR_STAGES  = 5,
   parameter int IO_STAGES  = 7,
   parameter int BR_STAGES  = 3,
   parameter int FLUSH_HOLD = 1,
   parameter int WMISS_STG  = 6
) (
   input  logic         clk,
   input  logic         n_RST,
`ifdef HAZARD_STATS_EN
   input  logic         stats_clr,
   output logic [31:0]  stall_cnt,
   output logic [15:0]  flush_cnt,
`endif
   hazard_unit_p_if.slave hz
);
   import hazard_pkg::*;

   localparam logic [HCNT_W-1:0] HOLD_INIT = HCNT_W'(FLUSH_HOLD);

   logic [BR_STAGES-1:0] br_pend;
   logic                 xfer;
   logic                 branch_c;
   logic                 flush_evt;
   logic                 dec_flush;
   logic [HCNT_W-1:0]    hcnt;
   logic                 hold_act;
   logic                 regf_hit;
   logic                 aux_hit;
   logic                 ovf_hit;
   logic                 io_hit;
   logic                 wr_req;
   logic                 rd_req;
   logic                 miss_stall;
   logic                 data_hz;

   assign br_pend   = hz.NZT | hz.XEC;
   assign xfer      = hz.JMP | hz.RET;
   assign branch_c  = xfer & (|br_pend);
   assign flush_evt = (hz.NZT_res & hz.ALU_NZ)
                    | hz.XEC_res
                    | hz.CALL_res;
   // A taken JMP/RET squashes the fetch behind it too.
   assign dec_flush = flush_evt | (xfer & ~branch_c);
   assign hold_act  = (hcnt != '0);

   always_ff @(posedge clk or negedge n_RST) begin
      if (!n_RST)         hcnt <= HOLD_INIT;
      else if (dec_flush) hcnt <= HOLD_INIT;
      else if (hold_act)  hcnt <= hcnt - 1'b1;
   end

   always_comb begin
      regf_hit = 1'b0;
      for (int k = 0; k < WR_STAGES; k++) begin
         if (hz.regf_wren[k] &&
             hz.regf_w[k*REG_AW +: REG_AW] == hz.regf_a_read)
            regf_hit = 1'b1;
      end
      regf_hit = regf_hit & (hz.read_src == SRC_REG);
   end

   // Aux register is address 0; only bit-1 stage can still hold it.
   assign aux_hit = hz.aux_read & hz.regf_wren[1]
                  & (hz.regf_w[REG_AW +: REG_AW] == '0);

   assign ovf_hit = (hz.read_src == SRC_OVF) & (|hz.ovf_wr);

   always_comb begin
      io_hit = 1'b0;
      for (int k = 0; k < IO_STAGES; k++) begin
         if (hz.SC[k] ||
             (hz.WC[k] && (hz.n_LB_w[k] == hz.n_LB_r)))
            io_hit = 1'b1;
      end
      io_hit = io_hit & (hz.read_src == SRC_IO);
   end

   assign wr_req = hz.d_cache_miss & hz.WC[WMISS_STG];
   assign rd_req = hz.d_cache_miss & (hz.read_src == SRC_IO);

   hazard_miss_fsm u_miss (
      .clk          (clk),
      .n_RST        (n_RST),
      .d_cache_miss (hz.d_cache_miss),
      .wr_req       (wr_req),
      .rd_req       (rd_req),
      .miss_stall   (miss_stall),
      .data_hazard  (data_hz)
   );

   assign hz.branch_hazard  = branch_c;
   assign hz.pipeline_flush = flush_evt;
   assign hz.data_hazard    = data_hz;
   assign hz.decoder_RST    = dec_flush | hold_act | ~n_RST;
   assign hz.hazard         = ~n_RST | dec_flush | hold_act
                            | regf_hit | aux_hit | ovf_hit
                            | io_hit | branch_c | miss_stall
                            | hz.HALT;

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge n_RST) begin
      if (!n_RST)                    stall_cnt <= '0;
      else if (stats_clr)            stall_cnt <= '0;
      else if (hz.hazard && ~&stall_cnt)
                                     stall_cnt <= stall_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge n_RST) begin
      if (!n_RST)                    flush_cnt <= '0;
      else if (stats_clr)            flush_cnt <= '0;
      else if (flush_evt && ~&flush_cnt)
                                     flush_cnt <= flush_cnt + 1'b1;
   end
`endif

endmodule
